// File: rtl/atm_keypad_entry_if.sv
// Keypad-entry bundle: key input stream, request handshake and status.
// master = keypad/controller side, slave = atm_keypad_entry.
interface atm_keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_ready;
    logic        req_valid;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
    logic [2:0]  operation;
    logic [2:0]  entry_state;
    logic [3:0]  digit_cnt;
    logic        abort;
    logic        timeout;

    modport master (
        output key_valid, key_code, req_ready,
        input  req_valid, acc_num, pin, new_pin, amount, operation,
               entry_state, digit_cnt, abort, timeout
    );

    modport slave (
        input  key_valid, key_code, req_ready,
        output req_valid, acc_num, pin, new_pin, amount, operation,
               entry_state, digit_cnt, abort, timeout
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM controller: assembles account, PIN, operation
// and amount / new PIN from serial key codes and offers the result on a
// valid/ready handshake. Handles CANCEL, entry timeout and field checks.
// Optional feature macro: ENTRY_BACKSPACE_EN (key 12 deletes the last digit).
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES    = 1000,
    parameter int MAX_AMOUNT_DIGITS = 6
) (
    input logic                  clk,
    input logic                  rst,
    atm_keypad_entry_if.slave    bus
);

`ifdef ENTRY_BACKSPACE_EN
    localparam bit BACKSPACE_EN = 1'b1;
`else
    localparam bit BACKSPACE_EN = 1'b0;
`endif

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] MAX_AMT = 4'(MAX_AMOUNT_DIGITS);

    localparam logic [3:0] K_ENTER  = 4'd10;
    localparam logic [3:0] K_CANCEL = 4'd11;
    localparam logic [3:0] K_BACK   = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACC    = 3'd1,
        S_PIN    = 3'd2,
        S_OP     = 3'd3,
        S_AMOUNT = 3'd4,
        S_NEWPIN = 3'd5,
        S_READY  = 3'd6
    } state_t;

    state_t               state_r, state_nxt;
    logic [3:0]           acc_r, acc_nxt;
    logic [15:0]          pin_r, pin_nxt;
    logic [15:0]          new_pin_r, new_pin_nxt;
    logic [31:0]          amount_r, amount_nxt;
    logic [2:0]           op_r, op_nxt;
    logic [3:0]           cnt_r, cnt_nxt;
    logic                 abort_r, abort_nxt;
    logic                 timeout_r, timeout_nxt;
    logic [TIMER_W-1:0]   timer_r, timer_nxt;

    logic                 is_digit;
    logic                 accepted;
    logic                 clear_all;
    logic [15:0]          field_cur, field_nxt;

    // State and field registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            acc_r     <= '0;
            pin_r     <= '0;
            new_pin_r <= '0;
            amount_r  <= '0;
            op_r      <= '0;
            cnt_r     <= '0;
            abort_r   <= 1'b0;
            timeout_r <= 1'b0;
            timer_r   <= '0;
        end else begin
            state_r   <= state_nxt;
            acc_r     <= acc_nxt;
            pin_r     <= pin_nxt;
            new_pin_r <= new_pin_nxt;
            amount_r  <= amount_nxt;
            op_r      <= op_nxt;
            cnt_r     <= cnt_nxt;
            abort_r   <= abort_nxt;
            timeout_r <= timeout_nxt;
            timer_r   <= timer_nxt;
        end
    end

    // Next-state, field update, cancel and timeout logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt   = state_r;
        acc_nxt     = acc_r;
        pin_nxt     = pin_r;
        new_pin_nxt = new_pin_r;
        amount_nxt  = amount_r;
        op_nxt      = op_r;
        cnt_nxt     = cnt_r;
        abort_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        timer_nxt   = timer_r;
        accepted    = 1'b0;
        clear_all   = 1'b0;
        is_digit    = (bus.key_code <= 4'd9);
        field_cur   = (state_r == S_NEWPIN) ? new_pin_r : pin_r;
        field_nxt   = field_cur;

        unique case (state_r)
            S_IDLE: begin
                if (bus.key_valid && is_digit) begin
                    acc_nxt   = bus.key_code;
                    cnt_nxt   = 4'd1;
                    state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (bus.key_valid && is_digit) begin
                    acc_nxt  = bus.key_code;
                    accepted = 1'b1;
                end else if (bus.key_valid && bus.key_code == K_ENTER) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_PIN;
                    accepted  = 1'b1;
                end
            end
            S_PIN, S_NEWPIN: begin
                if (bus.key_valid && is_digit && cnt_r < 4'd4) begin
                    field_nxt = {field_cur[11:0], bus.key_code};
                    cnt_nxt   = cnt_r + 4'd1;
                    accepted  = 1'b1;
                end else if (bus.key_valid && bus.key_code == K_ENTER && cnt_r == 4'd4) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = (state_r == S_PIN) ? S_OP : S_READY;
                    accepted  = 1'b1;
                end else if (BACKSPACE_EN && bus.key_valid && bus.key_code == K_BACK
                             && cnt_r != 4'd0) begin
                    field_nxt = {4'h0, field_cur[15:4]};
                    cnt_nxt   = cnt_r - 4'd1;
                    accepted  = 1'b1;
                end
                if (state_r == S_PIN) pin_nxt = field_nxt;
                else                  new_pin_nxt = field_nxt;
            end
            S_OP: begin
                if (bus.key_valid && is_digit && bus.key_code >= 4'd1 && bus.key_code <= 4'd5) begin
                    op_nxt   = bus.key_code[2:0];
                    accepted = 1'b1;
                end else if (bus.key_valid && bus.key_code == K_ENTER && op_r != 3'd0) begin
                    accepted = 1'b1;
                    unique case (op_r)
                        3'd1:       state_nxt = S_READY;
                        3'd2, 3'd3: state_nxt = S_AMOUNT;
                        3'd4:       state_nxt = S_NEWPIN;
                        default: begin
                            abort_nxt = 1'b1;
                            clear_all = 1'b1;
                        end
                    endcase
                end
            end
            S_AMOUNT: begin
                if (bus.key_valid && is_digit && cnt_r < MAX_AMT) begin
                    amount_nxt = amount_r * 32'd10 + {28'd0, bus.key_code};
                    cnt_nxt    = cnt_r + 4'd1;
                    accepted   = 1'b1;
                end else if (bus.key_valid && bus.key_code == K_ENTER && amount_r != 32'd0) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_READY;
                    accepted  = 1'b1;
                end else if (BACKSPACE_EN && bus.key_valid && bus.key_code == K_BACK
                             && cnt_r != 4'd0) begin
                    amount_nxt = amount_r / 32'd10;
                    cnt_nxt    = cnt_r - 4'd1;
                    accepted   = 1'b1;
                end
            end
            S_READY: begin
                if (bus.req_ready) clear_all = 1'b1;
            end
            default: clear_all = 1'b1;
        endcase

        // CANCEL aborts any partial entry; a presented request cannot be cancelled.
        if (bus.key_valid && bus.key_code == K_CANCEL
            && state_r != S_IDLE && state_r != S_READY) begin
            abort_nxt = 1'b1;
            clear_all = 1'b1;
            accepted  = 1'b1;
        end

        // Inactivity timer: accepted keys and state changes restart it.
        if (state_r == S_IDLE) begin
            timer_nxt = '0;
        end else if (state_r != S_READY) begin
            if (accepted || state_nxt != state_r) begin
                timer_nxt = '0;
            end else if (timer_r == TIMER_LAST) begin
                timeout_nxt = 1'b1;
                clear_all   = 1'b1;
            end else begin
                timer_nxt = timer_r + 1'b1;
            end
        end

        if (clear_all) begin
            state_nxt   = S_IDLE;
            acc_nxt     = '0;
            pin_nxt     = '0;
            new_pin_nxt = '0;
            amount_nxt  = '0;
            op_nxt      = '0;
            cnt_nxt     = '0;
            timer_nxt   = '0;
        end
    end

    assign bus.req_valid   = (state_r == S_READY);
    assign bus.acc_num     = acc_r;
    assign bus.pin         = pin_r;
    assign bus.new_pin     = new_pin_r;
    assign bus.amount      = amount_r;
    assign bus.operation   = op_r;
    assign bus.entry_state = state_r;
    assign bus.digit_cnt   = cnt_r;
    assign bus.abort       = abort_r;
    assign bus.timeout     = timeout_r;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed self-checking bench for atm_keypad_entry (default 1000-cycle timeout).
module tb_atm_keypad_entry;

    localparam int TIMEOUT_CYCLES = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    atm_keypad_entry_if kif ();

    atm_keypad_entry #(
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
        .MAX_AMOUNT_DIGITS (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: key is sampled on the next rising edge,
    // returns at the following falling edge with outputs updated.
    task automatic press(input logic [3:0] code);
        kif.key_valid = 1'b1;
        kif.key_code  = code;
        @(negedge clk);
        kif.key_valid = 1'b0;
        kif.key_code  = 4'd15;
    endtask

    task automatic press_seq(input logic [3:0] codes[], input int n);
        for (int i = 0; i < n; i++) press(codes[i]);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid"}, {31'd0, kif.req_valid}, 32'd0);
        check({tag, ".state"}, {29'd0, kif.entry_state}, 32'd0);
        check({tag, ".acc"},   {28'd0, kif.acc_num}, 32'd0);
        check({tag, ".pin"},   {16'd0, kif.pin}, 32'd0);
        check({tag, ".npin"},  {16'd0, kif.new_pin}, 32'd0);
        check({tag, ".amt"},   kif.amount, 32'd0);
        check({tag, ".op"},    {29'd0, kif.operation}, 32'd0);
        check({tag, ".cnt"},   {28'd0, kif.digit_cnt}, 32'd0);
    endtask

    initial begin
        logic [3:0] seq[];
        kif.key_valid = 1'b0;
        kif.key_code  = 4'd15;
        kif.req_ready = 1'b0;

        // Reset values
        #12;
        check_cleared("rst");
        check("rst.abort", {31'd0, kif.abort}, 32'd0);
        check("rst.tmo", {31'd0, kif.timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Withdraw 500 with req_ready high
        kif.req_ready = 1'b1;
        seq = '{4'd3, 4'd10, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd2, 4'd10, 4'd5, 4'd0, 4'd0, 4'd10};
        press_seq(seq, 13);
        check("wd.valid", {31'd0, kif.req_valid}, 32'd1);
        check("wd.state", {29'd0, kif.entry_state}, 32'd6);
        check("wd.acc", {28'd0, kif.acc_num}, 32'd3);
        check("wd.pin", {16'd0, kif.pin}, 32'h1234);
        check("wd.op", {29'd0, kif.operation}, 32'd2);
        check("wd.amt", kif.amount, 32'd500);
        check("wd.npin", {16'd0, kif.new_pin}, 32'd0);
        @(negedge clk);
        check_cleared("wd_done");

        // Change PIN with req_ready held low; keys ignored while waiting
        kif.req_ready = 1'b0;
        seq = '{4'd7, 4'd10, 4'd9, 4'd9, 4'd9, 4'd9, 4'd10, 4'd4, 4'd10, 4'd4, 4'd3, 4'd2, 4'd1, 4'd10};
        press_seq(seq, 14);
        check("cp.valid", {31'd0, kif.req_valid}, 32'd1);
        check("cp.npin", {16'd0, kif.new_pin}, 32'h4321);
        check("cp.op", {29'd0, kif.operation}, 32'd4);
        press(4'd5);
        press(4'd11);
        check("cp.cancel_abort", {31'd0, kif.abort}, 32'd0);
        repeat (8) @(negedge clk);
        check("cp.hold_valid", {31'd0, kif.req_valid}, 32'd1);
        check("cp.hold_npin", {16'd0, kif.new_pin}, 32'h4321);
        check("cp.hold_pin", {16'd0, kif.pin}, 32'h9999);
        check("cp.hold_acc", {28'd0, kif.acc_num}, 32'd7);
        check("cp.hold_amt", kif.amount, 32'd0);
        kif.req_ready = 1'b1;
        @(negedge clk);
        kif.req_ready = 1'b0;
        check_cleared("cp_done");

        // Short PIN ENTER ignored, 5th digit ignored, then CANCEL in OP
        seq = '{4'd1, 4'd10, 4'd1, 4'd2, 4'd3, 4'd10};
        press_seq(seq, 6);
        check("pin.state3", {29'd0, kif.entry_state}, 32'd2);
        check("pin.cnt3", {28'd0, kif.digit_cnt}, 32'd3);
        seq = '{4'd4, 4'd5, 4'd10};
        press_seq(seq, 3);
        check("pin.full", {16'd0, kif.pin}, 32'h1234);
        check("pin.op_state", {29'd0, kif.entry_state}, 32'd3);
        press(4'd7);
        press(4'd10);
        check("op.no_op_enter", {29'd0, kif.entry_state}, 32'd3);
        press(4'd11);
        check("op.cancel_abort", {31'd0, kif.abort}, 32'd1);
        check("op.cancel_state", {29'd0, kif.entry_state}, 32'd0);
        check("op.cancel_pin", {16'd0, kif.pin}, 32'd0);
        @(negedge clk);
        check("op.abort_pulse", {31'd0, kif.abort}, 32'd0);

        // Timeout after TIMEOUT_CYCLES idle cycles; ignored key 13 does not restart timer
        seq = '{4'd1, 4'd10, 4'd1, 4'd2};
        press_seq(seq, 4);
        repeat (500) @(negedge clk);
        press(4'd13);
        repeat (TIMEOUT_CYCLES - 2 - 500) @(negedge clk);
        check("tmo.before_state", {29'd0, kif.entry_state}, 32'd2);
        check("tmo.before_pulse", {31'd0, kif.timeout}, 32'd0);
        @(negedge clk);
        check("tmo.pulse", {31'd0, kif.timeout}, 32'd1);
        check("tmo.state", {29'd0, kif.entry_state}, 32'd0);
        check("tmo.pin", {16'd0, kif.pin}, 32'd0);
        check("tmo.acc", {28'd0, kif.acc_num}, 32'd0);
        @(negedge clk);
        check("tmo.pulse_end", {31'd0, kif.timeout}, 32'd0);

        // Op 5 exits with abort and no request
        seq = '{4'd2, 4'd10, 4'd1, 4'd1, 4'd1, 4'd1, 4'd10, 4'd5, 4'd10};
        press_seq(seq, 9);
        check("exit.abort", {31'd0, kif.abort}, 32'd1);
        check("exit.valid", {31'd0, kif.req_valid}, 32'd0);
        check("exit.op", {29'd0, kif.operation}, 32'd0);
        check("exit.state", {29'd0, kif.entry_state}, 32'd0);

        // Deposit: zero-amount ENTER ignored, 7th digit ignored
        seq = '{4'd2, 4'd10, 4'd1, 4'd1, 4'd1, 4'd1, 4'd10, 4'd3, 4'd10, 4'd10};
        press_seq(seq, 10);
        check("amt.zero_enter", {29'd0, kif.entry_state}, 32'd4);
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        press_seq(seq, 7);
        check("amt.value", kif.amount, 32'd123456);
        check("amt.cnt", {28'd0, kif.digit_cnt}, 32'd6);
        press(4'd10);
        check("amt.valid", {31'd0, kif.req_valid}, 32'd1);
        check("amt.op", {29'd0, kif.operation}, 32'd3);
        check("amt.final", kif.amount, 32'd123456);

        // Reset while a request is pending drops it immediately
        #2 rst = 1'b0;
        #1;
        check("rst_mid.valid", {31'd0, kif.req_valid}, 32'd0);
        check("rst_mid.amt", kif.amount, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Backspace in PIN field
`ifdef ENTRY_BACKSPACE_EN
        seq = '{4'd1, 4'd10, 4'd1, 4'd2, 4'd12, 4'd3, 4'd4, 4'd5, 4'd10};
        press_seq(seq, 9);
        check("bs.pin", {16'd0, kif.pin}, 32'h1345);
`else
        seq = '{4'd1, 4'd10, 4'd1, 4'd2, 4'd12, 4'd3, 4'd4, 4'd10};
        press_seq(seq, 8);
        check("bs.pin", {16'd0, kif.pin}, 32'h1234);
`endif
        check("bs.state", {29'd0, kif.entry_state}, 32'd3);
        press(4'd11);
        check("bs.cancel_state", {29'd0, kif.entry_state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
